// File: rtl/usb_rx_pkg.sv
// Shared encodings and constants for the USB full-speed receive front end.
package usb_rx_pkg;

    // Line-state encodings, {dm, dp} after synchronization.
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    // Receive FSM state encodings.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SYNC = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_EOP  = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    // Minimum decoded zeros before the SYNC-terminating 1 is accepted.
    localparam logic [2:0] SYNC_MIN_ZEROS = 3'd5;
    // Run of decoded ones after which a stuffed zero must follow.
    localparam logic [2:0] STUFF_LEN      = 3'd6;
    // Minimum SE0 samples that make a valid end-of-packet.
    localparam logic [1:0] EOP_MIN_SE0    = 2'd2;

endpackage

// File: rtl/usb_rx_line_sync.sv
// Two-flop synchronizers for the raw D+/D- pads and the resulting line state.
module usb_rx_line_sync
    import usb_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dp_in,
    input  logic       dm_in,
    output logic [1:0] line_state
);

    logic [1:0] dp_sync;
    logic [1:0] dm_sync;

    // Resolve pad metastability; reset to an idle J line (dp=1, dm=0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_sync <= 2'b11;
            dm_sync <= 2'b00;
        end else begin
            // NOTE: sequential state uses <= so every flop samples the pre-edge values.
            dp_sync <= {dp_sync[0], dp_in};
            dm_sync <= {dm_sync[0], dm_in};
        end
    end

    assign line_state = {dm_sync[1], dp_sync[1]};

endmodule

// File: rtl/usb_fs_rx_frontend.sv
// USB full-speed receive front end: bit-phase recovery, NRZI decode, SYNC
// detection, bit-unstuffing, byte assembly and EOP detection.
// Optional: define USB_RX_ERR_COUNT_EN to build the saturating error counter;
// otherwise err_count is tied to 00h.
module usb_fs_rx_frontend
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       dp_in,
    input  logic       dm_in,
    input  logic       rx_enable,
    output logic [1:0] line_state,
    output logic       rx_active,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error,
    output logic       eop,
    output logic [7:0] err_count
);

    localparam int              PH_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLKS_PER_BIT - 1);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(CLKS_PER_BIT / 2);

    logic [1:0]      prev_line_state;
    logic [PH_W-1:0] phase;
    logic            sample;
    logic [1:0]      last_level;
    logic            is_jk;
    logic            bit_val;

    logic [2:0]      state;
    logic [2:0]      zero_cnt;
    logic [2:0]      ones_cnt;
    logic [2:0]      bit_cnt;
    logic [1:0]      se0_cnt;
    logic [7:0]      shift_reg;

    usb_rx_line_sync u_line_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .dp_in      (dp_in),
        .dm_in      (dm_in),
        .line_state (line_state)
    );

    // Bit-phase recovery: realign on every line transition, free-run otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_line_state <= LS_J;
            phase           <= '0;
        end else begin
            prev_line_state <= line_state;
            if (line_state != prev_line_state || phase == PH_LAST)
                phase <= '0;
            else
                phase <= phase + PH_W'(1);
        end
    end

    assign sample = (phase == PH_MID);

    // NRZI decode: a 1 is "no change" relative to the previous J/K sample.
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        is_jk   = 1'b0;
        bit_val = 1'b0;
        if (line_state == LS_J || line_state == LS_K) begin
            is_jk   = 1'b1;
            bit_val = (line_state == last_level);
        end
    end

    // Receive FSM, unstuffing, byte assembly and one-cycle output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_level <= LS_J;
            state      <= ST_IDLE;
            zero_cnt   <= '0;
            ones_cnt   <= '0;
            bit_cnt    <= '0;
            se0_cnt    <= '0;
            shift_reg  <= '0;
            rx_data    <= '0;
            rx_active  <= 1'b0;
            rx_valid   <= 1'b0;
            rx_error   <= 1'b0;
            eop        <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
            eop      <= 1'b0;

            if (sample && is_jk)
                last_level <= line_state;

            if (!ena || !rx_enable) begin
                state     <= ST_IDLE;
                rx_active <= 1'b0;
                zero_cnt  <= '0;
                ones_cnt  <= '0;
                bit_cnt   <= '0;
                se0_cnt   <= '0;
            end else if (sample) begin
                case (state)
                    ST_IDLE: begin
                        if (line_state == LS_K) begin
                            state    <= ST_SYNC;
                            zero_cnt <= 3'd1;
                        end
                    end

                    ST_SYNC: begin
                        if (!is_jk) begin
                            state <= ST_IDLE;
                        end else if (!bit_val) begin
                            if (zero_cnt != 3'd7)
                                zero_cnt <= zero_cnt + 3'd1;
                        end else if (zero_cnt >= SYNC_MIN_ZEROS) begin
                            state     <= ST_DATA;
                            rx_active <= 1'b1;
                            ones_cnt  <= '0;
                            bit_cnt   <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end

                    ST_DATA: begin
                        if (line_state == LS_SE0) begin
                            state   <= ST_EOP;
                            se0_cnt <= 2'd1;
                        end else if (is_jk) begin
                            if (ones_cnt == STUFF_LEN) begin
                                // The bit after six ones must be a stuffed zero.
                                if (bit_val) begin
                                    rx_error  <= 1'b1;
                                    rx_active <= 1'b0;
                                    state     <= ST_ERR;
                                end else begin
                                    ones_cnt <= '0;
                                end
                            end else begin
                                shift_reg <= {bit_val, shift_reg[7:1]};
                                ones_cnt  <= bit_val ? ones_cnt + 3'd1 : 3'd0;
                                if (bit_cnt == 3'd7) begin
                                    rx_data  <= {bit_val, shift_reg[7:1]};
                                    rx_valid <= 1'b1;
                                    bit_cnt  <= '0;
                                end else begin
                                    bit_cnt <= bit_cnt + 3'd1;
                                end
                            end
                        end
                    end

                    ST_EOP: begin
                        if (line_state == LS_SE0) begin
                            if (se0_cnt != 2'd3)
                                se0_cnt <= se0_cnt + 2'd1;
                        end else if (line_state == LS_J && se0_cnt >= EOP_MIN_SE0) begin
                            eop       <= 1'b1;
                            rx_error  <= (bit_cnt != 3'd0);
                            rx_active <= 1'b0;
                            bit_cnt   <= '0;
                            state     <= ST_IDLE;
                        end else begin
                            rx_error  <= 1'b1;
                            rx_active <= 1'b0;
                            state     <= ST_ERR;
                        end
                    end

                    ST_ERR: begin
                        if (line_state == LS_J)
                            state <= ST_IDLE;
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef USB_RX_ERR_COUNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of rx_error pulses; cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt_q <= '0;
        else if (rx_error && err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_usb_fs_rx_frontend.sv
// Scoreboard bench for usb_fs_rx_frontend: an NRZI/bit-stuff encoder drives the
// pads, expected strobes are queued as symbols are sent and popped as they appear.
module tb_usb_fs_rx_frontend;
    import usb_rx_pkg::*;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       dp_in;
    logic       dm_in;
    logic       rx_enable;
    logic [1:0] line_state;
    logic       rx_active;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic       eop;
    logic [7:0] err_count;

    always #10 clk = ~clk;

    usb_fs_rx_frontend #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .dp_in      (dp_in),
        .dm_in      (dm_in),
        .rx_enable  (rx_enable),
        .line_state (line_state),
        .rx_active  (rx_active),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_error   (rx_error),
        .eop        (eop),
        .err_count  (err_count)
    );

    typedef enum logic [1:0] {EV_VALID, EV_EOP, EV_ERR, EV_EOP_ERR} ev_kind_t;
    typedef struct packed {
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    int         checks = 0;
    int         errors = 0;
    ev_t        exp_q[$];
    logic [1:0] level = LS_J;
    int         ones = 0;
    int         exp_err = 0;
    logic       prev_valid = 1'b0;
    logic       prev_error = 1'b0;
    logic       prev_eop = 1'b0;

    function automatic logic [1:0] flip(input logic [1:0] l);
        return (l == LS_J) ? LS_K : LS_J;
    endfunction

    function automatic logic [7:0] exp_err_count();
`ifdef USB_RX_ERR_COUNT_EN
        return (exp_err > 255) ? 8'hFF : 8'(exp_err);
`else
        return 8'h00;
`endif
    endfunction

    // Compare any strobe the DUT shows against the head of the scoreboard.
    task automatic monitor();
        ev_t obs;
        ev_t want;
        if (rx_valid || rx_error || eop) begin
            if (eop && rx_error)  obs.kind = EV_EOP_ERR;
            else if (eop)         obs.kind = EV_EOP;
            else if (rx_error)    obs.kind = EV_ERR;
            else                  obs.kind = EV_VALID;
            obs.data = rx_data;

            checks++;
            if (rx_valid && eop) begin
                errors++;
                $display("FAIL valid_eop_overlap: rx_valid=%b eop=%b, required not both", rx_valid, eop);
            end

            checks++;
            if ((rx_valid && prev_valid) || (rx_error && prev_error) || (eop && prev_eop)) begin
                errors++;
                $display("FAIL strobe_width: valid/error/eop=%b%b%b after %b%b%b, required single-cycle",
                         rx_valid, rx_error, eop, prev_valid, prev_error, prev_eop);
            end

            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: kind=%0d data=%02h, required no strobe", obs.kind, obs.data);
            end else begin
                want = exp_q.pop_front();
                if (obs.kind !== want.kind || (want.kind == EV_VALID && obs.data !== want.data)) begin
                    errors++;
                    $display("FAIL strobe_match: kind=%0d data=%02h, required kind=%0d data=%02h",
                             obs.kind, obs.data, want.kind, want.data);
                end
            end
        end
        prev_valid = rx_valid;
        prev_error = rx_error;
        prev_eop   = eop;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        monitor();
    endtask

    task automatic drive_ls(input logic [1:0] ls);
        {dm_in, dp_in} = ls;
        repeat (CPB) tick();
    endtask

    task automatic idle(input int n);
        level = LS_J;
        repeat (n) drive_ls(LS_J);
    endtask

    task automatic send_sync();
        logic [1:0] pat [8];
        pat = '{LS_K, LS_J, LS_K, LS_J, LS_K, LS_J, LS_K, LS_K};
        for (int i = 0; i < 8; i++) drive_ls(pat[i]);
        level = LS_K;
        ones  = 0;
    endtask

    task automatic send_bit(input logic b);
        if (!b) level = flip(level);
        drive_ls(level);
        if (b) begin
            ones++;
            if (ones == 6) begin
                level = flip(level);
                drive_ls(level);
                ones = 0;
            end
        end else begin
            ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        ev_t e;
        e.kind = EV_VALID;
        e.data = b;
        exp_q.push_back(e);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_eop(input logic partial);
        ev_t e;
        e.kind = partial ? EV_EOP_ERR : EV_EOP;
        e.data = 8'h00;
        if (partial) exp_err++;
        exp_q.push_back(e);
        drive_ls(LS_SE0);
        drive_ls(LS_SE0);
        level = LS_J;
        drive_ls(LS_J);
        ones = 0;
    endtask

    // Wait a bounded time for all expected strobes, then watch for stragglers.
    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d strobes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4 * CPB) tick();
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({line_state, rx_active, rx_valid, rx_error, eop, rx_data, err_count} !==
            {LS_J, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL %s: ls=%b act=%b val=%b err=%b eop=%b data=%02h cnt=%02h, required ls=01 others 0",
                     name, line_state, rx_active, rx_valid, rx_error, eop, rx_data, err_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; rx_enable = 1'b1;
        {dm_in, dp_in} = LS_K;
        repeat (3) @(negedge clk);
        check_reset_values("reset_state");
        {dm_in, dp_in} = LS_J;
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
    endtask

    task automatic test_basic_packet();
        send_sync();
        send_byte(8'hA5);
        checks++;
        if (rx_active !== 1'b1) begin
            errors++;
            $display("FAIL basic_rx_active_high: rx_active=%b, required 1", rx_active);
        end
        send_eop(1'b0);
        idle(2);
        drain("basic");
        checks++;
        if (rx_active !== 1'b0 || rx_data !== 8'hA5) begin
            errors++;
            $display("FAIL basic_after_eop: rx_active=%b rx_data=%02h, required 0 and A5", rx_active, rx_data);
        end
    endtask

    task automatic test_bit_stuff();
        send_sync();
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h7E);
        send_eop(1'b0);
        idle(2);
        drain("stuff");
    endtask

    task automatic test_stuff_error();
        ev_t e;
        send_sync();
        e.kind = EV_ERR;
        e.data = 8'h00;
        exp_q.push_back(e);
        exp_err++;
        repeat (7) drive_ls(level);
        drain("stuff_err");
        checks++;
        if (rx_active !== 1'b0) begin
            errors++;
            $display("FAIL stuff_err_rx_active: rx_active=%b, required 0", rx_active);
        end
        checks++;
        if (err_count !== exp_err_count()) begin
            errors++;
            $display("FAIL stuff_err_count: err_count=%02h, required %02h", err_count, exp_err_count());
        end
        idle(3);
    endtask

    task automatic test_partial_eop();
        send_sync();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_eop(1'b1);
        idle(2);
        drain("partial_eop");
        checks++;
        if (err_count !== exp_err_count()) begin
            errors++;
            $display("FAIL partial_eop_count: err_count=%02h, required %02h", err_count, exp_err_count());
        end
    endtask

    task automatic test_rx_enable_drop();
        send_sync();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        checks++;
        if (rx_active !== 1'b1) begin
            errors++;
            $display("FAIL rxen_active_before: rx_active=%b, required 1", rx_active);
        end
        rx_enable = 1'b0;
        tick();
        checks++;
        if (rx_active !== 1'b0) begin
            errors++;
            $display("FAIL rxen_active_after: rx_active=%b, required 0", rx_active);
        end
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        idle(3);
        rx_enable = 1'b1;
        idle(2);
        send_sync();
        send_byte(8'h5A);
        send_eop(1'b0);
        idle(2);
        drain("rxen_recover");
    endtask

    task automatic test_reset_mid_packet();
        idle(2);
        send_sync();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst_n = 1'b0;
        exp_err = 0;
        #1;
        check_reset_values("midreset_immediate");
        send_bit(1'b0);
        send_bit(1'b1);
        check_reset_values("midreset_held");
        rst_n = 1'b1;
        idle(3);
        send_sync();
        send_byte(8'h3C);
        send_eop(1'b0);
        idle(2);
        drain("midreset_recover");
        checks++;
        if (rx_data !== 8'h3C) begin
            errors++;
            $display("FAIL midreset_rx_data: rx_data=%02h, required 3C", rx_data);
        end
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_bit_stuff();
        test_stuff_error();
        test_partial_eop();
        test_rx_enable_drop();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/usb_fs_rx_frontend.md
USB_FS_RX_FRONTEND -- requirements
Module: usb_fs_rx_frontend

Interface
REQ-001 The block SHALL have one parameter, `CLKS_PER_BIT`, default 4, giving clk cycles per full-speed bit (48 MHz clk at 12 Mbps).
REQ-002 The ports SHALL be, one per line:
  - clk  in  1  sole clock, 48 MHz
  - rst_n  in  1  reset, asynchronous, active-low
  - ena  in  1  design enable; low holds the block in IDLE
  - dp_in  in  1  raw Data+ pad, asynchronous to clk
  - dm_in  in  1  raw Data- pad, asynchronous to clk
  - rx_enable  in  1  low while the device transmits; forces IDLE
  - line_state  out  2  synchronized line state: 00 SE0, 01 J, 10 K, 11 SE1
  - rx_active  out  1  high from SYNC accepted to EOP or error
  - rx_data  out  8  last assembled byte, LSB first on the wire
  - rx_valid  out  1  one-cycle strobe; rx_data is new
  - rx_error  out  1  one-cycle strobe on a stuff error or a partial byte at EOP
  - eop  out  1  one-cycle strobe on a valid end-of-packet
  - err_count  out  8  saturating error count (see Configuration)

Function
REQ-003 dp_in and dm_in SHALL each pass through a 2-flop synchronizer; line_state SHALL equal {dm,dp} after synchronization, re-encoded per REQ-002.
REQ-004 The bit-phase counter SHALL reset to 0 in every cycle where line_state differs from its previous value, and wrap CLKS_PER_BIT-1 -> 0 otherwise.
REQ-005 A sample strobe SHALL fire when phase == CLKS_PER_BIT/2.
REQ-006 The NRZI decoded bit SHALL be 1 when the sampled J/K level equals the previous sampled level, and 0 otherwise.
REQ-007 The FSM SHALL have states IDLE, SYNC, DATA, EOP and ERR.
REQ-008 IDLE -> SYNC on the first sampled K.
REQ-009 SYNC SHALL count decoded 0s; a decoded 1 after at least 5 zeros -> DATA with rx_active=1; a decoded 1 after fewer than 5 zeros, or an SE0, -> IDLE.
REQ-010 In DATA, after six consecutive decoded 1s the next bit SHALL be discarded if it is 0.
REQ-011 If that bit is 1, the block SHALL pulse rx_error, set rx_active=0 and go to ERR.
REQ-012 ERR SHALL hold until line_state is J for at least 1 sample -> IDLE.
REQ-013 Non-stuff bits SHALL shift into an 8-bit register LSB first.
REQ-014 On the 8th bit, rx_data SHALL update and rx_valid SHALL pulse in the clk cycle after the sample strobe (1-cycle latency); rx_data SHALL hold until the next byte.
REQ-015 In DATA, an SE0 sample SHALL -> EOP.
REQ-016 In EOP, a J sample after at least 2 SE0 samples SHALL pulse eop and set rx_active=0, -> IDLE.
REQ-017 In EOP, a J after only 1 SE0, or a K, SHALL pulse rx_error and go to ERR.
REQ-018 A nonzero bit count at EOP SHALL pulse rx_error and eop in the same cycle.
REQ-019 rx_enable=0 or ena=0 SHALL force IDLE within 1 cycle, drop rx_active, suppress all strobes, and clear the stuff and bit counters.
REQ-020 rx_valid, rx_error and eop SHALL never be high for more than 1 consecutive cycle.
REQ-021 rx_valid and eop SHALL never be high in the same cycle.

Reset
REQ-022 While rst_n=0: state IDLE, synchronizers holding J (01), all counters 0, rx_data=00h, rx_active=rx_valid=rx_error=eop=0, err_count=0.
REQ-023 Reset assertion mid-packet SHALL abort immediately with no strobes.
REQ-024 After reset release, a new packet SHALL require a fresh SYNC.

Configuration
REQ-025 With `USB_RX_ERR_COUNT_EN` defined, err_count SHALL increment on every rx_error pulse and saturate at FFh; it clears only on reset.
REQ-026 Without `USB_RX_ERR_COUNT_EN`, err_count SHALL be tied to 00h and no counter logic is built.

Structure
REQ-027 Package `usb_rx_pkg` SHALL hold the line-state encodings, the FSM state encodings, and the constants SYNC_MIN_ZEROS=5, STUFF_LEN=6 and EOP_MIN_SE0=2.
REQ-028 Sub-module `usb_rx_line_sync` SHALL implement the synchronizers and line_state; all else lives in usb_fs_rx_frontend.

Verification
REQ-029 Idle J, then KJKJKJKK followed by byte A5h, then SE0 SE0 J -> rx_active rises, one rx_valid with rx_data=A5h, then eop=1; rx_error never asserted.
REQ-030 Payload FFh FFh (bit-stuff inserted after six 1s) -> two rx_valid strobes, both with FFh, and no rx_error.
REQ-031 Seven consecutive NRZI 1s (no stuff bit) -> rx_error pulse; rx_active=0; state ERR until J; err_count=1 with the macro defined, 0 without.
REQ-032 SYNC followed by 3 bits then SE0 SE0 J -> eop and rx_error in the same cycle; no rx_valid.
REQ-033 rx_enable dropped mid-byte, then restored -> rx_active=0 next cycle, no strobes, and the next clean packet is received correctly.
REQ-034 rst_n asserted mid-packet -> all outputs at reset values while low; after release, a SYNC with byte 3Ch -> rx_data=3Ch.
